// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined main-control unit: opcode and ALU-op
// constants, the control bundle carried down the pipe, and the opcode decoder.
package pipe_ctrl_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_R   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ = 2'b01;
  localparam logic [1:0] ALUOP_SW  = 2'b10;
  localparam logic [1:0] ALUOP_ADD = 2'b11;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic [1:0] aluop;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       regwrite;
    logic       memtoreg;
  } ctrl_bundle_t;

  // Unknown opcodes fall into the default arm and decode as a NOP bundle.
  function automatic ctrl_bundle_t decode_opcode(input logic [OPCODE_W-1:0] opc);
    ctrl_bundle_t c;
    c = '0;
    case (opc)
      OP_RTYPE: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = ALUOP_R;
      end
      OP_LW: begin
        c.alusrc   = 1'b1;
        c.memread  = 1'b1;
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = ALUOP_ADD;
      end
      OP_SW: begin
        c.alusrc   = 1'b1;
        c.memwrite = 1'b1;
        c.aluop    = ALUOP_SW;
      end
      OP_BEQ: begin
        c.branch   = 1'b1;
        c.aluop    = ALUOP_BEQ;
      end
      OP_ADDI: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = ALUOP_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Instructions that read rt as a source operand (rt is a destination for
  // LW/ADDI, so it must not trigger a load-use stall there).
  function automatic logic opc_uses_rt(input logic [OPCODE_W-1:0] opc);
    return (opc == OP_RTYPE) || (opc == OP_SW) || (opc == OP_BEQ);
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Bus between the pipeline control unit and its surroundings.
//   master : ID stage / branch unit side - drives instruction and hold/flush.
//   slave  : pipe_ctrl_unit - returns hazard_stall and per-stage controls.
interface pipe_ctrl_unit_if #(
  parameter int INSTR_W = 32,
  parameter int REG_AW  = 5
);
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic               stall_ext;
  logic               flush_ex;
  logic               hazard_stall;
  logic               ex_regdst;
  logic               ex_alusrc;
  logic [1:0]         ex_aluop;
  logic [REG_AW-1:0]  ex_dst;
  logic               mem_read;
  logic               mem_write;
  logic               mem_branch;
  logic [REG_AW-1:0]  mem_dst;
  logic               wb_regwrite;
  logic               wb_memtoreg;
  logic [REG_AW-1:0]  wb_dst;

  modport master (
    output id_valid, id_instr, stall_ext, flush_ex,
    input  hazard_stall, ex_regdst, ex_alusrc, ex_aluop, ex_dst,
           mem_read, mem_write, mem_branch, mem_dst,
           wb_regwrite, wb_memtoreg, wb_dst
  );

  modport slave (
    input  id_valid, id_instr, stall_ext, flush_ex,
    output hazard_stall, ex_regdst, ex_alusrc, ex_aluop, ex_dst,
           mem_read, mem_write, mem_branch, mem_dst,
           wb_regwrite, wb_memtoreg, wb_dst
  );
endinterface

// File: rtl/pipe_ctrl_hazard.sv
// Load-use hazard comparator. Raises hazard_stall_o when the instruction in
// ID reads the register a load currently in EX is about to write.
//   id_valid_i   : ID holds a real instruction
//   uses_rt_i    : ID instruction reads rt
//   rs_i, rt_i   : ID source register fields
//   ex_memread_i : EX-stage instruction is a load
//   ex_dst_i     : EX-stage resolved destination
//   hazard_stall_o : combinational stall request
module pipe_ctrl_hazard #(
  parameter int REG_AW    = 5,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic              id_valid_i,
  input  logic              uses_rt_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_dst_i,
  output logic              hazard_stall_o
);
  logic dst_live, rs_hit, rt_hit;

  // $0 is never really written, so a load into it cannot create a dependency.
  assign dst_live = (ex_dst_i != '0);
  assign rs_hit   = (ex_dst_i == rs_i);
  assign rt_hit   = (ex_dst_i == rt_i) && uses_rt_i;

  // With HAZARD_EN=0 this folds to a constant 0.
  assign hazard_stall_o = HAZARD_EN && id_valid_i && ex_memread_i && dst_live &&
                          (rs_hit || rt_hit);
endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main-control unit. Decodes the ID opcode into a control bundle,
// carries it through ID/EX, EX/MEM and MEM/WB, inserts a bubble on load-use
// hazards, taken-branch flush or an idle ID slot, and freezes on stall_ext.
//   clk_i   : rising-edge clock
//   reset_i : synchronous active-high reset, clears all stage registers
//   bus     : pipe_ctrl_unit_if slave (instruction/hold/flush in, controls out)
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int INSTR_W   = 32,
  parameter int OPC_HI    = 31,
  parameter int OPC_LO    = 26,
  parameter int REG_AW    = 5,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic           clk_i,
  input  logic           reset_i,
  pipe_ctrl_unit_if.slave bus
);
  localparam int OPC_W = OPC_HI - OPC_LO + 1;
  localparam int RS_LO = OPC_LO - REG_AW;
  localparam int RT_LO = OPC_LO - 2*REG_AW;
  localparam int RD_LO = OPC_LO - 3*REG_AW;

  typedef struct packed {
    ctrl_bundle_t      c;
    logic [REG_AW-1:0] dst;
  } ex_stage_t;

  typedef struct packed {
    logic              memread;
    logic              memwrite;
    logic              branch;
    logic              regwrite;
    logic              memtoreg;
    logic [REG_AW-1:0] dst;
  } mem_stage_t;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic [REG_AW-1:0] dst;
  } wb_stage_t;

  logic [OPCODE_W-1:0] opc;
  logic [REG_AW-1:0]   rs, rt, rd;
  ctrl_bundle_t        id_ctrl;
  logic [REG_AW-1:0]   id_dst;
  logic                hazard;
  logic                bubble;

  ex_stage_t  ex_q,  ex_d;
  mem_stage_t mem_q, mem_d;
  wb_stage_t  wb_q,  wb_d;

  // Fields below rd (shamt/funct) are not needed for main control.
  logic unused_instr;
  assign unused_instr = ^bus.id_instr;

  assign opc = OPCODE_W'(bus.id_instr[OPC_HI:OPC_LO]);
  assign rs  = bus.id_instr[RS_LO +: REG_AW];
  assign rt  = bus.id_instr[RT_LO +: REG_AW];
  assign rd  = bus.id_instr[RD_LO +: REG_AW];

  always_comb begin
    id_ctrl = decode_opcode(opc);
    id_dst  = id_ctrl.regdst ? rd : rt;
    // A write to $0 is dropped here so later stages never see it.
    if (id_dst == '0) id_ctrl.regwrite = 1'b0;
  end

  pipe_ctrl_hazard #(
    .REG_AW    (REG_AW),
    .HAZARD_EN (HAZARD_EN)
  ) u_hazard (
    .id_valid_i     (bus.id_valid),
    .uses_rt_i      (opc_uses_rt(opc)),
    .rs_i           (rs),
    .rt_i           (rt),
    .ex_memread_i   (ex_q.c.memread),
    .ex_dst_i       (ex_q.dst),
    .hazard_stall_o (hazard)
  );

  // Flush and hazard collapse into the same single bubble.
  assign bubble = hazard || bus.flush_ex || !bus.id_valid;

  always_comb begin
    ex_d = bubble ? '0 : ex_stage_t'{c: id_ctrl, dst: id_dst};

    mem_d          = '0;
    mem_d.memread  = ex_q.c.memread;
    mem_d.memwrite = ex_q.c.memwrite;
    mem_d.branch   = ex_q.c.branch;
    mem_d.regwrite = ex_q.c.regwrite;
    mem_d.memtoreg = ex_q.c.memtoreg;
    mem_d.dst      = ex_q.dst;

    wb_d          = '0;
    wb_d.regwrite = mem_q.regwrite;
    wb_d.memtoreg = mem_q.memtoreg;
    wb_d.dst      = mem_q.dst;
  end

  // stall_ext freezes every stage, including pending bubbles and flushes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!bus.stall_ext) begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign bus.hazard_stall = hazard;
  assign bus.ex_regdst    = ex_q.c.regdst;
  assign bus.ex_alusrc    = ex_q.c.alusrc;
  assign bus.ex_aluop     = ex_q.c.aluop;
  assign bus.ex_dst       = ex_q.dst;
  assign bus.mem_read     = mem_q.memread;
  assign bus.mem_write    = mem_q.memwrite;
  assign bus.mem_branch   = mem_q.branch;
  assign bus.mem_dst      = mem_q.dst;
  assign bus.wb_regwrite  = wb_q.regwrite;
  assign bus.wb_memtoreg  = wb_q.memtoreg;
  assign bus.wb_dst       = wb_q.dst;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed scenarios plus randomized traffic,
// checked against a history-queue model of the control pipe. A second
// instance built with HAZARD_EN=0 must never raise hazard_stall.
module tb_pipe_ctrl_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_ctrl_unit_if #(.INSTR_W(32), .REG_AW(5)) bus    ();
  pipe_ctrl_unit_if #(.INSTR_W(32), .REG_AW(5)) bus_nh ();

  pipe_ctrl_unit #(.HAZARD_EN(1'b1)) u_dut (
    .clk_i(clk), .reset_i(reset), .bus(bus.slave)
  );
  pipe_ctrl_unit #(.HAZARD_EN(1'b0)) u_dut_nh (
    .clk_i(clk), .reset_i(reset), .bus(bus_nh.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic obs_hz;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    bit       regdst, alusrc;
    bit [1:0] aluop;
    bit       memread, memwrite, branch, regwrite, memtoreg;
    bit [4:0] dst;
  } mb_t;

  // Every bundle that has entered EX, newest last; stage k sits k-1 back.
  mb_t hist[$];

  function automatic mb_t m_decode(input bit [31:0] i);
    mb_t m = '0;
    case (i[31:26])
      6'b000000: begin m.regdst = 1; m.regwrite = 1; m.aluop = 2'b00; end
      6'b100011: begin m.alusrc = 1; m.memread = 1; m.memtoreg = 1; m.regwrite = 1; m.aluop = 2'b11; end
      6'b101011: begin m.alusrc = 1; m.memwrite = 1; m.aluop = 2'b10; end
      6'b000100: begin m.branch = 1; m.aluop = 2'b01; end
      6'b001000: begin m.alusrc = 1; m.regwrite = 1; m.aluop = 2'b11; end
      default: ;
    endcase
    m.dst = m.regdst ? i[15:11] : i[20:16];
    if (m.dst == 0) m.regwrite = 0;
    return m;
  endfunction

  function automatic mb_t stage(input int k);
    if (hist.size() >= k) return hist[hist.size()-k];
    return '0;
  endfunction

  function automatic bit reads_rt(input bit [5:0] op);
    return op == 6'b000000 || op == 6'b101011 || op == 6'b000100;
  endfunction

  function automatic bit [31:0] rtype(input int rs, input int rt, input int rd);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 11'h020};
  endfunction

  function automatic bit [31:0] itype(input bit [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // One cycle: drive, check against model before the edge, advance model.
  task automatic step(input bit v, input bit [31:0] ins, input bit st,
                      input bit fl, input bit rst);
    mb_t ex, mem, wb, nb;
    bit  hz;
    bus.id_valid = v;  bus.id_instr = ins;  bus.stall_ext = st;  bus.flush_ex = fl;
    bus_nh.id_valid = v; bus_nh.id_instr = ins; bus_nh.stall_ext = st; bus_nh.flush_ex = fl;
    reset = rst;
    @(negedge clk);
    ex = stage(1); mem = stage(2); wb = stage(3);
    hz = v && ex.memread && ex.dst != 0 &&
         (ex.dst == ins[25:21] || (ex.dst == ins[20:16] && reads_rt(ins[31:26])));
    chk("ex",  64'({bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_dst}),
               64'({ex.regdst, ex.alusrc, ex.aluop, ex.dst}));
    chk("mem", 64'({bus.mem_read, bus.mem_write, bus.mem_branch, bus.mem_dst}),
               64'({mem.memread, mem.memwrite, mem.branch, mem.dst}));
    chk("wb",  64'({bus.wb_regwrite, bus.wb_memtoreg, bus.wb_dst}),
               64'({wb.regwrite, wb.memtoreg, wb.dst}));
    chk("hazard", 64'(bus.hazard_stall), 64'(hz));
    chk("hazard_off", 64'(bus_nh.hazard_stall), 64'(0));
    obs_hz = bus.hazard_stall;
    if (rst) hist.delete();
    else if (!st) begin
      nb = (hz || fl || !v) ? mb_t'('0) : m_decode(ins);
      hist.push_back(nb);
      if (hist.size() > 3) void'(hist.pop_front());
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    bit [5:0] ops [7];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b111111, 6'b010101};

    reset = 1'b1;
    bus.id_valid = 0; bus.id_instr = '0; bus.stall_ext = 0; bus.flush_ex = 0;
    bus_nh.id_valid = 0; bus_nh.id_instr = '0; bus_nh.stall_ext = 0; bus_nh.flush_ex = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held two cycles with a load applied, then released.
    step(1, itype(6'b100011, 5, 4, 0), 0, 0, 1);
    step(1, itype(6'b100011, 5, 4, 0), 0, 0, 1);
    chk("rst_all", 64'({bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_dst,
                        bus.mem_read, bus.mem_write, bus.mem_branch, bus.mem_dst,
                        bus.wb_regwrite, bus.wb_memtoreg, bus.wb_dst}), 64'(0));
    idle(1);

    // R, LW, SW, BEQ, ADDI stream.
    step(1, rtype(1, 2, 3), 0, 0, 0);
    chk("s_aluop_r", 64'(bus.ex_aluop), 64'(2'b00));
    chk("s_dst_r",   64'(bus.ex_dst), 64'(3));
    step(1, itype(6'b100011, 5, 4, 0), 0, 0, 0);
    chk("s_aluop_lw", 64'(bus.ex_aluop), 64'(2'b11));
    chk("s_dst_lw",   64'(bus.ex_dst), 64'(4));
    step(1, itype(6'b101011, 7, 6, 4), 0, 0, 0);
    chk("s_aluop_sw", 64'(bus.ex_aluop), 64'(2'b10));
    chk("s_mw_early", 64'(bus.mem_write), 64'(0));
    step(1, itype(6'b000100, 1, 2, 3), 0, 0, 0);
    chk("s_aluop_beq", 64'(bus.ex_aluop), 64'(2'b01));
    chk("s_mw_sw",     64'(bus.mem_write), 64'(1));
    chk("s_m2r_lw",    64'(bus.wb_memtoreg), 64'(1));
    step(1, itype(6'b001000, 0, 8, 5), 0, 0, 0);
    chk("s_aluop_addi", 64'(bus.ex_aluop), 64'(2'b11));
    chk("s_dst_addi",   64'(bus.ex_dst), 64'(8));
    chk("s_mw_late",    64'(bus.mem_write), 64'(0));
    idle(3);

    // Load-use: LW $4 then R reading $4.
    step(1, itype(6'b100011, 5, 4, 0), 0, 0, 0);
    step(1, rtype(4, 2, 9), 0, 0, 0);
    chk("lu_hz1", 64'(obs_hz), 64'(1));
    chk("lu_bubble", 64'({bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_dst}), 64'(0));
    step(1, rtype(4, 2, 9), 0, 0, 0);
    chk("lu_hz2", 64'(obs_hz), 64'(0));
    chk("lu_dst", 64'(bus.ex_dst), 64'(9));
    idle(3);

    // Load into $0 never stalls; R with rd=0 never writes back.
    step(1, itype(6'b100011, 5, 0, 0), 0, 0, 0);
    step(1, rtype(0, 0, 10), 0, 0, 0);
    chk("z_hz", 64'(obs_hz), 64'(0));
    step(1, rtype(1, 2, 0), 0, 0, 0);
    idle(2);
    chk("z_wbrw", 64'(bus.wb_regwrite), 64'(0));
    idle(1);

    // Flush coincident with a hazard, then a 3-cycle global stall.
    step(1, itype(6'b100011, 5, 4, 0), 0, 0, 0);
    step(1, rtype(4, 2, 9), 0, 1, 0);
    chk("fh_hz", 64'(obs_hz), 64'(1));
    step(1, rtype(4, 2, 9), 0, 0, 0);
    step(1, itype(6'b001000, 1, 8, 2), 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, itype(6'b101011, 3, 3, 0), 1, (i == 1), 0);
      chk("st_exdst",  64'(bus.ex_dst), 64'(8));
      chk("st_memdst", 64'(bus.mem_dst), 64'(9));
      chk("st_aluop",  64'(bus.ex_aluop), 64'(2'b11));
    end
    idle(3);

    // Illegal opcode and idle slot both give a NOP bundle.
    step(1, {6'b111111, 26'h0}, 0, 0, 0);
    chk("ill_ex", 64'({bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_dst}), 64'(0));
    step(0, rtype(1, 2, 3), 0, 0, 0);
    chk("inv_ex", 64'({bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_dst}), 64'(0));
    idle(3);

    // Randomized traffic over a small register set to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      bit [31:0] ins;
      ins = {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
             5'($urandom_range(0, 5)), 11'($urandom)};
      step(($urandom % 8) != 0, ins, ($urandom % 8) == 0, ($urandom % 10) == 0,
           ($urandom % 80) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Parametrised, pipelined successor to the combinational main-control decoder.
- Decodes the opcode field of the ID-stage instruction into a control bundle.
- Carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers.
- Adds load-use hazard detection (bubble insertion), branch flush and global stall hold. Sits beside the datapath pipeline registers.

Parameters:
- INSTR_W, 32: instruction width.
- OPC_HI, 31: opcode field MSB.
- OPC_LO, 26: opcode field LSB. OPC_HI-OPC_LO+1 = OPC_W.
- REG_AW, 5: register-address width. rs/rt/rd are at [25:21]/[20:16]/[15:11] for defaults, generalised as consecutive REG_AW fields directly below the opcode.
- HAZARD_EN, 1: 1 = load-use detection active; 0 = hazard_stall tied 0.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- id_valid, in, 1: id_instr holds a real instruction.
- id_instr, in, INSTR_W: ID-stage instruction.
- stall_ext, in, 1: global hold of all control stage registers.
- flush_ex, in, 1: branch resolved taken; squash the instruction entering EX.
- hazard_stall, out, 1: combinational; holds PC and IF/ID when 1.
- ex_regdst, ex_alusrc, out, 1 each: EX-stage controls.
- ex_aluop, out, 2: ALU operation class. R=00, BEQ=01, SW=10, LW/ADDI=11.
- ex_dst, out, REG_AW: resolved destination register.
- mem_read, mem_write, mem_branch, out, 1 each: MEM-stage controls.
- mem_dst, out, REG_AW.
- wb_regwrite, wb_memtoreg, out, 1 each: WB-stage controls.
- wb_dst, out, REG_AW.

Behaviour:
- Reset: synchronous, active-high. All stage registers clear to 0, so every output except hazard_stall is 0 on the cycle after reset is sampled. hazard_stall is then 0 because ex_memread=0. Reset mid-operation discards all in-flight control and has priority over every other input.
- Decode is combinational on the opcode:
  - R 000000: regdst=1, regwrite=1, aluop=00.
  - LW 100011: alusrc=1, memread=1, memtoreg=1, regwrite=1, aluop=11.
  - SW 101011: alusrc=1, memwrite=1, aluop=10.
  - BEQ 000100: branch=1, aluop=01.
  - ADDI 001000: alusrc=1, regwrite=1, aluop=11.
  - Any other opcode decodes as an all-zero bundle (NOP), never X.
- Destination: dst = regdst ? rd : rt. If dst==0, regwrite is forced 0 and dst is carried as 0.
- Latency: a bundle accepted at edge N appears on ex_* after N, mem_* after N+1, wb_* after N+2. The EX, MEM and WB fields shift one stage per edge.
- Bubble: ID/EX loads an all-zero bundle when (hazard_stall | flush_ex | ~id_valid) and stall_ext=0.
- stall_ext=1: all three stage registers hold. This overrides flush_ex and hazard bubbles. A pending flush must be re-asserted by the branch unit after the stall.
- Load-use hazard: hazard_stall = HAZARD_EN & id_valid & ex_memread & (ex_dst!=0) & ((ex_dst==rs) | (ex_dst==rt & uses_rt)). uses_rt is true for R, SW and BEQ.
- Hazard duration: exactly one bubble per load-use pair. The next cycle ex_memread=0, so the stall releases without external help.
- Simultaneous flush_ex and hazard_stall: a single bubble is inserted; behaviour is identical to flush alone.
- EX/MEM and MEM/WB are never bubbled internally; only reset and stall_ext affect them.

Decomposition:
- Package pipe_ctrl_pkg:
  - Opcode constants.
  - ALUop constants.
  - Packed struct ctrl_bundle_t {regdst, alusrc, aluop[1:0], memread, memwrite, branch, regwrite, memtoreg}.
  - Function decode_opcode returning ctrl_bundle_t.
- One natural sub-module: pipe_ctrl_hazard, holding the load-use comparator that produces hazard_stall. The top module instantiates it and owns the three stage registers.

Test Plan:
- Reset: assert reset 2 cycles with LW applied -> all outputs 0 and hazard_stall 0 throughout and on the first cycle after release.
- Stream R(add $3,$1,$2), LW $4,0($5), SW $6,4($7), BEQ, ADDI $8 on consecutive cycles -> ex_aluop 00,11,10,01,11. Then:
  - ex_dst: 3, 4, 8 for R/LW/ADDI.
  - mem_write: 1 exactly 2 cycles after SW is applied.
  - wb_memtoreg: 1 exactly 3 cycles after LW is applied.
- LW $4 then R using rs=$4 -> hazard_stall=1 for exactly 1 cycle and one all-zero EX bundle. R reaches EX one cycle later, with ex_dst=its rd.
- LW $0 followed by a user of $0 -> no stall. R with rd=0 -> wb_regwrite=0.
- flush_ex asserted together with hazard_stall, then stall_ext held 3 cycles mid-stream -> one bubble only, and all ex_/mem_/wb_ values frozen for 3 cycles.
- Illegal opcode 111111 and id_valid=0 -> all-zero bundle propagates. HAZARD_EN=0 build -> hazard_stall constant 0.
